// File: rtl/pcie_us_cq_reg_completer_if.sv
// rtl/pcie_us_cq_reg_completer_if.sv - CQ/CC stream and register bus bundle for the BAR0 completer
//
// Purpose: groups the hard-IP CQ request stream, the CC completion stream,
// the simple register bus and the timeout status into one interface.
// Modports:
//   master - completer side: sinks CQ, sources CC, drives the register bus
//   slave  - environment side: hard IP plus register file
// Signals:
//   s_axis_cq_*  CQ request beats (tuser[3:0] = first_be)
//   m_axis_cc_*  CC completion beats (tuser tied to 0)
//   reg_*        single-DW register access, strobes held until reg_ack
//   stat_timeout one-cycle pulse per abandoned access
interface pcie_us_cq_reg_completer_if #(
  parameter int AXIS_PCIE_DATA_WIDTH    = 512,
  parameter int AXIS_PCIE_KEEP_WIDTH    = AXIS_PCIE_DATA_WIDTH / 32,
  parameter int AXIS_PCIE_CQ_USER_WIDTH = 183,
  parameter int AXIS_PCIE_CC_USER_WIDTH = 81,
  parameter int REG_ADDR_WIDTH          = 24
);
  logic [AXIS_PCIE_DATA_WIDTH-1:0]    s_axis_cq_tdata;
  logic [AXIS_PCIE_KEEP_WIDTH-1:0]    s_axis_cq_tkeep;
  logic                               s_axis_cq_tvalid;
  logic                               s_axis_cq_tready;
  logic                               s_axis_cq_tlast;
  logic [AXIS_PCIE_CQ_USER_WIDTH-1:0] s_axis_cq_tuser;

  logic [AXIS_PCIE_DATA_WIDTH-1:0]    m_axis_cc_tdata;
  logic [AXIS_PCIE_KEEP_WIDTH-1:0]    m_axis_cc_tkeep;
  logic                               m_axis_cc_tvalid;
  logic                               m_axis_cc_tready;
  logic                               m_axis_cc_tlast;
  logic [AXIS_PCIE_CC_USER_WIDTH-1:0] m_axis_cc_tuser;

  logic [REG_ADDR_WIDTH-1:0]          reg_addr;
  logic                               reg_wr_en;
  logic [31:0]                        reg_wr_data;
  logic [3:0]                         reg_wr_strb;
  logic                               reg_rd_en;
  logic [31:0]                        reg_rd_data;
  logic                               reg_ack;

  logic                               stat_timeout;

  modport master (
    input  s_axis_cq_tdata, s_axis_cq_tkeep, s_axis_cq_tvalid, s_axis_cq_tlast, s_axis_cq_tuser,
    output s_axis_cq_tready,
    output m_axis_cc_tdata, m_axis_cc_tkeep, m_axis_cc_tvalid, m_axis_cc_tlast, m_axis_cc_tuser,
    input  m_axis_cc_tready,
    output reg_addr, reg_wr_en, reg_wr_data, reg_wr_strb, reg_rd_en,
    input  reg_rd_data, reg_ack,
    output stat_timeout
  );

  modport slave (
    output s_axis_cq_tdata, s_axis_cq_tkeep, s_axis_cq_tvalid, s_axis_cq_tlast, s_axis_cq_tuser,
    input  s_axis_cq_tready,
    input  m_axis_cc_tdata, m_axis_cc_tkeep, m_axis_cc_tvalid, m_axis_cc_tlast, m_axis_cc_tuser,
    output m_axis_cc_tready,
    input  reg_addr, reg_wr_en, reg_wr_data, reg_wr_strb, reg_rd_en,
    output reg_rd_data, reg_ack,
    input  stat_timeout
  );
endinterface

// File: rtl/pcie_us_cq_reg_completer.sv
// rtl/pcie_us_cq_reg_completer.sv - BAR0 single-DW register completer on UltraScale+ CQ/CC
//
// Purpose: accepts host memory read/write TLPs from CQ, performs one access
// on the register bus per valid single-DW BAR0 request, and returns a CC
// completion for every read (CA for unsupported reads or timed-out reads).
// Ports:
//   clk  - user clock
//   rst  - asynchronous active-high reset
//   bus  - pcie_us_cq_reg_completer_if.master (CQ in, CC out, register bus, stat_timeout)
module pcie_us_cq_reg_completer #(
  parameter int REG_ADDR_WIDTH = 24,
  parameter int TIMEOUT        = 1024
) (
  input  logic                         clk,
  input  logic                         rst,
  pcie_us_cq_reg_completer_if.master   bus
);
  localparam int CW = $clog2(TIMEOUT) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DROP,
    S_WR,
    S_RD,
    S_CPL
  } state_t;

  state_t                    r_state;
  state_t                    w_next;
  state_t                    r_pend;
  state_t                    w_pend_next;
  state_t                    w_target;

  // Holds tready low for the first cycle after reset so every output reads 0 in reset.
  logic                      r_active;
  logic [CW-1:0]             r_cnt;

  logic [REG_ADDR_WIDTH-1:2] r_addr;
  logic [3:0]                r_be;
  logic [31:0]               r_wdata;
  logic [15:0]               r_req_id;
  logic [7:0]                r_tag;
  logic [2:0]                r_tc;
  logic [2:0]                r_attr;
  logic [2:0]                r_status;
  logic [31:0]               r_rdata;

  logic                      w_cq_ready;
  logic                      w_cq_fire;
  logic [3:0]                w_req_type;
  logic [10:0]               w_dw_cnt;
  logic [2:0]                w_bar_id;
  logic [3:0]                w_first_be;
  logic                      w_is_rd;
  logic                      w_is_wr;
  logic                      w_single;
  logic                      w_in_access;
  logic                      w_timeout;
  logic [1:0]                w_lo;
  logic [511:0]              w_cc_data;
  logic                      w_unused;

  assign w_req_type = bus.s_axis_cq_tdata[78:75];
  assign w_dw_cnt   = bus.s_axis_cq_tdata[74:64];
  assign w_bar_id   = bus.s_axis_cq_tdata[114:112];
  assign w_first_be = bus.s_axis_cq_tuser[3:0];
  assign w_is_rd    = (w_req_type == 4'b0000);
  assign w_is_wr    = (w_req_type == 4'b0001);
  assign w_single   = (w_bar_id == 3'd0) && (w_dw_cnt == 11'd1);

  assign w_cq_ready  = r_active && ((r_state == S_IDLE) || (r_state == S_DROP));
  assign w_cq_fire   = bus.s_axis_cq_tvalid && w_cq_ready;
  assign w_in_access = (r_state == S_WR) || (r_state == S_RD);
  // An ack on the final counted cycle wins over the timeout.
  assign w_timeout   = w_in_access && !bus.reg_ack && (r_cnt == CW'(TIMEOUT - 1));

  // Where a freshly accepted request is headed once its last beat is in.
  always_comb begin
    w_target = S_IDLE;
    if (w_is_wr && w_single && (w_first_be != 4'd0)) begin
      w_target = S_WR;
    end else if (w_is_rd && w_single) begin
      w_target = S_RD;
    end else if (w_is_rd) begin
      w_target = S_CPL;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_pend_next = r_pend;
    case (r_state)
      S_IDLE: begin
        if (w_cq_fire) begin
          if (bus.s_axis_cq_tlast) begin
            w_next = w_target;
          end else begin
            w_next      = S_DROP;
            w_pend_next = w_target;
          end
        end
      end
      S_DROP: begin
        if (w_cq_fire && bus.s_axis_cq_tlast) begin
          w_next = r_pend;
        end
      end
      S_WR: begin
        if (bus.reg_ack || w_timeout) begin
          w_next = S_IDLE;
        end
      end
      S_RD: begin
        if (bus.reg_ack || w_timeout) begin
          w_next = S_CPL;
        end
      end
      S_CPL: begin
        if (bus.m_axis_cc_tready) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_pend   <= S_IDLE;
      r_active <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_state  <= w_next;
      r_pend   <= w_pend_next;
      r_active <= 1'b1;
      // Outside WR/RD the counter sits at 0, so each entry starts a fresh window.
      if (w_in_access && (w_next == r_state)) begin
        r_cnt <= r_cnt + 1'b1;
      end else begin
        r_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr   <= '0;
      r_be     <= '0;
      r_wdata  <= '0;
      r_req_id <= '0;
      r_tag    <= '0;
      r_tc     <= '0;
      r_attr   <= '0;
      r_status <= '0;
      r_rdata  <= '0;
    end else begin
      if ((r_state == S_IDLE) && w_cq_fire) begin
        r_addr   <= bus.s_axis_cq_tdata[REG_ADDR_WIDTH-1:2];
        r_be     <= w_first_be;
        r_wdata  <= bus.s_axis_cq_tdata[159:128];
        r_req_id <= bus.s_axis_cq_tdata[95:80];
        r_tag    <= bus.s_axis_cq_tdata[103:96];
        r_tc     <= bus.s_axis_cq_tdata[123:121];
        r_attr   <= bus.s_axis_cq_tdata[126:124];
        r_status <= (w_is_rd && !w_single) ? 3'b100 : 3'b000;
        r_rdata  <= '0;
      end else if (r_state == S_RD) begin
        if (bus.reg_ack) begin
          r_rdata  <= bus.reg_rd_data;
          r_status <= 3'b000;
        end else if (w_timeout) begin
          r_rdata  <= '0;
          r_status <= 3'b100;
        end
      end
    end
  end

  // Byte offset of the first enabled byte for the completion lower address.
  always_comb begin
    w_lo = 2'd0;
    if (r_be[0]) begin
      w_lo = 2'd0;
    end else if (r_be[1]) begin
      w_lo = 2'd1;
    end else if (r_be[2]) begin
      w_lo = 2'd2;
    end else if (r_be[3]) begin
      w_lo = 2'd3;
    end
  end

  always_comb begin
    w_cc_data = '0;
    if (r_state == S_CPL) begin
      w_cc_data[6:0]    = {r_addr[6:2], w_lo};
      w_cc_data[28:16]  = 13'd4;
      w_cc_data[42:32]  = 11'd1;
      w_cc_data[45:43]  = r_status;
      w_cc_data[63:48]  = r_req_id;
      w_cc_data[71:64]  = r_tag;
      w_cc_data[91:89]  = r_tc;
      w_cc_data[94:92]  = r_attr;
      w_cc_data[127:96] = r_rdata;
    end
  end

  assign bus.s_axis_cq_tready = w_cq_ready;

  assign bus.m_axis_cc_tdata  = w_cc_data;
  assign bus.m_axis_cc_tkeep  = (r_state == S_CPL) ? 16'h000F : 16'h0000;
  assign bus.m_axis_cc_tvalid = (r_state == S_CPL);
  assign bus.m_axis_cc_tlast  = (r_state == S_CPL);
  assign bus.m_axis_cc_tuser  = '0;

  assign bus.reg_addr    = w_in_access ? {r_addr, 2'b00} : '0;
  assign bus.reg_wr_en   = (r_state == S_WR);
  assign bus.reg_wr_data = (r_state == S_WR) ? r_wdata : 32'd0;
  assign bus.reg_wr_strb = (r_state == S_WR) ? r_be : 4'd0;
  assign bus.reg_rd_en   = (r_state == S_RD);
  assign bus.stat_timeout = w_timeout;

  // Descriptor bits this completer never looks at.
  assign w_unused = ^{bus.s_axis_cq_tdata[511:160], bus.s_axis_cq_tdata[127],
                      bus.s_axis_cq_tdata[120:115], bus.s_axis_cq_tdata[111:104],
                      bus.s_axis_cq_tdata[79], bus.s_axis_cq_tdata[63:REG_ADDR_WIDTH],
                      bus.s_axis_cq_tdata[1:0], bus.s_axis_cq_tkeep,
                      bus.s_axis_cq_tuser[182:4]};
endmodule

// File: tb/tb_pcie_us_cq_reg_completer.sv
// tb/tb_pcie_us_cq_reg_completer.sv - directed self-checking bench for the BAR0 register completer
module tb_pcie_us_cq_reg_completer;
  logic clk;
  logic rst;
  int   errors;
  int   checks;

  pcie_us_cq_reg_completer_if #(
    .AXIS_PCIE_DATA_WIDTH(512),
    .AXIS_PCIE_CQ_USER_WIDTH(183),
    .AXIS_PCIE_CC_USER_WIDTH(81),
    .REG_ADDR_WIDTH(24)
  ) bus_if ();

  pcie_us_cq_reg_completer #(
    .REG_ADDR_WIDTH(24),
    .TIMEOUT(1024)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  initial begin
    clk = 1'b0;
    forever #2 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got running want done");
    $fatal(1, "watchdog");
  end

  function automatic logic [511:0] cq_desc(input logic [63:0] addr, input logic [10:0] dwc,
                                           input logic [3:0] rt, input logic [15:0] rid,
                                           input logic [7:0] tag, input logic [2:0] bar,
                                           input logic [2:0] tc, input logic [2:0] attr,
                                           input logic [31:0] wd);
    logic [511:0] d;
    d = '0;
    d[63:2]    = addr[63:2];
    d[74:64]   = dwc;
    d[78:75]   = rt;
    d[95:80]   = rid;
    d[103:96]  = tag;
    d[114:112] = bar;
    d[123:121] = tc;
    d[126:124] = attr;
    d[159:128] = wd;
    d[511:480] = 32'hFFFF_FFFF;
    return d;
  endfunction

  function automatic logic [511:0] exp_cc(input logic [6:0] la, input logic [2:0] st,
                                          input logic [15:0] rid, input logic [7:0] tag,
                                          input logic [2:0] tc, input logic [2:0] attr,
                                          input logic [31:0] data);
    logic [511:0] d;
    d = '0;
    d[6:0]    = la;
    d[28:16]  = 13'd4;
    d[42:32]  = 11'd1;
    d[45:43]  = st;
    d[63:48]  = rid;
    d[71:64]  = tag;
    d[91:89]  = tc;
    d[94:92]  = attr;
    d[127:96] = data;
    return d;
  endfunction

  task automatic send_beat(input logic [511:0] d, input logic [3:0] be, input logic last);
    int n;
    n = 0;
    bus_if.s_axis_cq_tdata  = d;
    bus_if.s_axis_cq_tuser  = {179'd0, be};
    bus_if.s_axis_cq_tlast  = last;
    bus_if.s_axis_cq_tvalid = 1'b1;
    while (bus_if.s_axis_cq_tready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n >= 50) begin
      errors++;
      $display("FAIL cq_accept: tready got %b want 1 within 50 cycles", bus_if.s_axis_cq_tready);
    end
    @(posedge clk); #1;
    bus_if.s_axis_cq_tvalid = 1'b0;
    bus_if.s_axis_cq_tlast  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus_if.s_axis_cq_tready !== 1'b0 || bus_if.m_axis_cc_tvalid !== 1'b0 ||
        bus_if.reg_wr_en !== 1'b0 || bus_if.reg_rd_en !== 1'b0 || bus_if.stat_timeout !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%b ccv=%b wr=%b rd=%b to=%b want all 0",
               bus_if.s_axis_cq_tready, bus_if.m_axis_cc_tvalid, bus_if.reg_wr_en,
               bus_if.reg_rd_en, bus_if.stat_timeout);
    end
    checks++;
    if (bus_if.m_axis_cc_tdata !== 512'd0 || bus_if.reg_addr !== 24'd0) begin
      errors++;
      $display("FAIL reset_data: got cc=%h addr=%h want 0", bus_if.m_axis_cc_tdata[127:0], bus_if.reg_addr);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus_if.s_axis_cq_tready !== 1'b1) begin
      errors++;
      $display("FAIL idle_ready: got %b want 1", bus_if.s_axis_cq_tready);
    end
  endtask

  task automatic test_write();
    send_beat(cq_desc(64'h10, 11'd1, 4'b0001, 16'h0100, 8'h01, 3'd0, 3'd0, 3'd0, 32'hA5A5_1234), 4'hF, 1'b1);
    checks++;
    if (bus_if.reg_wr_en !== 1'b1 || bus_if.reg_addr !== 24'h000010 ||
        bus_if.reg_wr_data !== 32'hA5A5_1234 || bus_if.reg_wr_strb !== 4'hF ||
        bus_if.s_axis_cq_tready !== 1'b0 || bus_if.reg_rd_en !== 1'b0) begin
      errors++;
      $display("FAIL write_access: got en=%b addr=%h data=%h strb=%h rdy=%b want 1 000010 a5a51234 f 0",
               bus_if.reg_wr_en, bus_if.reg_addr, bus_if.reg_wr_data, bus_if.reg_wr_strb,
               bus_if.s_axis_cq_tready);
    end
    bus_if.reg_ack = 1'b1;
    @(posedge clk); #1;
    bus_if.reg_ack = 1'b0;
    checks++;
    if (bus_if.reg_wr_en !== 1'b0 || bus_if.s_axis_cq_tready !== 1'b1 || bus_if.m_axis_cc_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL write_done: got wr=%b rdy=%b ccv=%b want 0 1 0",
               bus_if.reg_wr_en, bus_if.s_axis_cq_tready, bus_if.m_axis_cc_tvalid);
    end
    // first_be = 0 skips the register access entirely
    send_beat(cq_desc(64'h14, 11'd1, 4'b0001, 16'h0100, 8'h02, 3'd0, 3'd0, 3'd0, 32'h1111_2222), 4'h0, 1'b1);
    checks++;
    if (bus_if.reg_wr_en !== 1'b0 || bus_if.s_axis_cq_tready !== 1'b1) begin
      errors++;
      $display("FAIL write_be0: got wr=%b rdy=%b want 0 1", bus_if.reg_wr_en, bus_if.s_axis_cq_tready);
    end
  endtask

  task automatic test_read_backpressure();
    logic [511:0] exp;
    exp = exp_cc(7'h04, 3'b000, 16'h0100, 8'h2C, 3'd2, 3'd1, 32'hDEAD_BEEF);
    send_beat(cq_desc(64'h104, 11'd1, 4'b0000, 16'h0100, 8'h2C, 3'd0, 3'd2, 3'd1, 32'h0), 4'hF, 1'b1);
    checks++;
    if (bus_if.reg_rd_en !== 1'b1 || bus_if.reg_addr !== 24'h000104 || bus_if.reg_wr_en !== 1'b0) begin
      errors++;
      $display("FAIL read_access: got rd=%b addr=%h wr=%b want 1 000104 0",
               bus_if.reg_rd_en, bus_if.reg_addr, bus_if.reg_wr_en);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (bus_if.reg_rd_en !== 1'b1 || bus_if.m_axis_cc_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL read_hold: got rd=%b ccv=%b want 1 0", bus_if.reg_rd_en, bus_if.m_axis_cc_tvalid);
    end
    bus_if.reg_ack          = 1'b1;
    bus_if.reg_rd_data      = 32'hDEAD_BEEF;
    bus_if.m_axis_cc_tready = 1'b0;
    @(posedge clk); #1;
    bus_if.reg_ack     = 1'b0;
    bus_if.reg_rd_data = 32'h0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus_if.m_axis_cc_tvalid !== 1'b1 || bus_if.m_axis_cc_tdata !== exp ||
          bus_if.m_axis_cc_tkeep !== 16'h000F || bus_if.m_axis_cc_tlast !== 1'b1 ||
          bus_if.s_axis_cq_tready !== 1'b0 || bus_if.reg_rd_en !== 1'b0) begin
        errors++;
        $display("FAIL read_cpl_stall%0d: got v=%b k=%h l=%b rdy=%b d=%h want 1 000f 1 0 d=%h",
                 i, bus_if.m_axis_cc_tvalid, bus_if.m_axis_cc_tkeep, bus_if.m_axis_cc_tlast,
                 bus_if.s_axis_cq_tready, bus_if.m_axis_cc_tdata[127:0], exp[127:0]);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (bus_if.m_axis_cc_tvalid !== 1'b1 || bus_if.m_axis_cc_tdata !== exp) begin
      errors++;
      $display("FAIL read_cpl_final: got v=%b d=%h want 1 %h",
               bus_if.m_axis_cc_tvalid, bus_if.m_axis_cc_tdata[127:0], exp[127:0]);
    end
    bus_if.m_axis_cc_tready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus_if.m_axis_cc_tvalid !== 1'b0 || bus_if.s_axis_cq_tready !== 1'b1) begin
      errors++;
      $display("FAIL read_cpl_done: got v=%b rdy=%b want 0 1", bus_if.m_axis_cc_tvalid, bus_if.s_axis_cq_tready);
    end
  endtask

  task automatic test_read_latency();
    logic [511:0] exp;
    exp = exp_cc(7'h0A, 3'b000, 16'h0001, 8'h05, 3'd0, 3'd0, 32'h1234_5678);
    send_beat(cq_desc(64'h08, 11'd1, 4'b0000, 16'h0001, 8'h05, 3'd0, 3'd0, 3'd0, 32'h0), 4'b0100, 1'b1);
    bus_if.reg_ack     = 1'b1;
    bus_if.reg_rd_data = 32'h1234_5678;
    @(posedge clk); #1;
    bus_if.reg_ack     = 1'b0;
    bus_if.reg_rd_data = 32'h0;
    checks++;
    if (bus_if.m_axis_cc_tvalid !== 1'b1 || bus_if.m_axis_cc_tdata !== exp) begin
      errors++;
      $display("FAIL read_latency: got v=%b d=%h want 1 %h",
               bus_if.m_axis_cc_tvalid, bus_if.m_axis_cc_tdata[127:0], exp[127:0]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_unsupported();
    logic [511:0] exp;
    exp = exp_cc(7'h20, 3'b100, 16'h0300, 8'h11, 3'd0, 3'd0, 32'h0);
    send_beat(cq_desc(64'h20, 11'd2, 4'b0000, 16'h0300, 8'h11, 3'd0, 3'd0, 3'd0, 32'h0), 4'hF, 1'b1);
    checks++;
    if (bus_if.m_axis_cc_tvalid !== 1'b1 || bus_if.m_axis_cc_tdata !== exp || bus_if.reg_rd_en !== 1'b0) begin
      errors++;
      $display("FAIL ca_dwcount: got v=%b rd=%b d=%h want 1 0 %h",
               bus_if.m_axis_cc_tvalid, bus_if.reg_rd_en, bus_if.m_axis_cc_tdata[127:0], exp[127:0]);
    end
    @(posedge clk); #1;
    exp = exp_cc(7'h25, 3'b100, 16'h0300, 8'h12, 3'd0, 3'd0, 32'h0);
    send_beat(cq_desc(64'h24, 11'd1, 4'b0000, 16'h0300, 8'h12, 3'd1, 3'd0, 3'd0, 32'h0), 4'b0010, 1'b1);
    checks++;
    if (bus_if.m_axis_cc_tvalid !== 1'b1 || bus_if.m_axis_cc_tdata !== exp || bus_if.reg_rd_en !== 1'b0) begin
      errors++;
      $display("FAIL ca_bar1: got v=%b rd=%b d=%h want 1 0 %h",
               bus_if.m_axis_cc_tvalid, bus_if.reg_rd_en, bus_if.m_axis_cc_tdata[127:0], exp[127:0]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_two_beat_write();
    send_beat(cq_desc(64'h30, 11'd1, 4'b0001, 16'h0100, 8'h07, 3'd0, 3'd0, 3'd0, 32'hCAFE_0001), 4'h3, 1'b0);
    checks++;
    if (bus_if.s_axis_cq_tready !== 1'b1 || bus_if.reg_wr_en !== 1'b0) begin
      errors++;
      $display("FAIL drop_beat1: got rdy=%b wr=%b want 1 0", bus_if.s_axis_cq_tready, bus_if.reg_wr_en);
    end
    send_beat(512'h0, 4'h0, 1'b1);
    checks++;
    if (bus_if.reg_wr_en !== 1'b1 || bus_if.reg_addr !== 24'h000030 ||
        bus_if.reg_wr_strb !== 4'h3 || bus_if.reg_wr_data !== 32'hCAFE_0001 ||
        bus_if.s_axis_cq_tready !== 1'b0) begin
      errors++;
      $display("FAIL drop_write: got wr=%b addr=%h strb=%h data=%h rdy=%b want 1 000030 3 cafe0001 0",
               bus_if.reg_wr_en, bus_if.reg_addr, bus_if.reg_wr_strb, bus_if.reg_wr_data,
               bus_if.s_axis_cq_tready);
    end
    bus_if.reg_ack = 1'b1;
    @(posedge clk); #1;
    bus_if.reg_ack = 1'b0;
    checks++;
    if (bus_if.reg_wr_en !== 1'b0 || bus_if.s_axis_cq_tready !== 1'b1) begin
      errors++;
      $display("FAIL drop_write_done: got wr=%b rdy=%b want 0 1", bus_if.reg_wr_en, bus_if.s_axis_cq_tready);
    end
  endtask

  task automatic test_timeout();
    logic [511:0] exp;
    int pulse_idx;
    int pulse_cnt;
    exp = exp_cc(7'h40, 3'b100, 16'h0200, 8'h33, 3'd0, 3'd0, 32'h0);
    pulse_idx = 0;
    pulse_cnt = 0;
    send_beat(cq_desc(64'h40, 11'd1, 4'b0000, 16'h0200, 8'h33, 3'd0, 3'd0, 3'd0, 32'h0), 4'hF, 1'b1);
    for (int i = 1; i <= 1100; i++) begin
      if (bus_if.m_axis_cc_tvalid === 1'b1) break;
      if (bus_if.stat_timeout === 1'b1) begin
        pulse_cnt++;
        pulse_idx = i;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (pulse_idx != 1024 || pulse_cnt != 1) begin
      errors++;
      $display("FAIL timeout_pulse: got cycle=%0d count=%0d want cycle=1024 count=1", pulse_idx, pulse_cnt);
    end
    checks++;
    if (bus_if.m_axis_cc_tvalid !== 1'b1 || bus_if.m_axis_cc_tdata !== exp || bus_if.reg_rd_en !== 1'b0) begin
      errors++;
      $display("FAIL timeout_cpl: got v=%b rd=%b d=%h want 1 0 %h",
               bus_if.m_axis_cc_tvalid, bus_if.reg_rd_en, bus_if.m_axis_cc_tdata[127:0], exp[127:0]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_read();
    send_beat(cq_desc(64'h50, 11'd1, 4'b0000, 16'h0200, 8'h44, 3'd0, 3'd0, 3'd0, 32'h0), 4'hF, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checks++;
    if (bus_if.reg_rd_en !== 1'b0 || bus_if.s_axis_cq_tready !== 1'b0 ||
        bus_if.m_axis_cc_tvalid !== 1'b0 || bus_if.reg_addr !== 24'd0 || bus_if.stat_timeout !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_rd: got rd=%b rdy=%b ccv=%b addr=%h to=%b want all 0",
               bus_if.reg_rd_en, bus_if.s_axis_cq_tready, bus_if.m_axis_cc_tvalid,
               bus_if.reg_addr, bus_if.stat_timeout);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus_if.s_axis_cq_tready !== 1'b1 || bus_if.reg_rd_en !== 1'b0 || bus_if.m_axis_cc_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_rd_idle: got rdy=%b rd=%b ccv=%b want 1 0 0",
               bus_if.s_axis_cq_tready, bus_if.reg_rd_en, bus_if.m_axis_cc_tvalid);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    bus_if.s_axis_cq_tdata  = '0;
    bus_if.s_axis_cq_tkeep  = '0;
    bus_if.s_axis_cq_tvalid = 1'b0;
    bus_if.s_axis_cq_tlast  = 1'b0;
    bus_if.s_axis_cq_tuser  = '0;
    bus_if.m_axis_cc_tready = 1'b1;
    bus_if.reg_rd_data      = 32'h0;
    bus_if.reg_ack          = 1'b0;
    test_reset();
    test_write();
    test_read_backpressure();
    test_read_latency();
    test_unsupported();
    test_two_beat_write();
    test_timeout();
    test_reset_mid_read();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
